// File: rtl/ifetch_pkg.sv
// Shared encodings for the instruction fetch stage: RV32I opcodes, immediate
// extender modes (also consumed by the downstream extender) and the fetch FSM states.
package ifetch_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [2:0] EXT_I     = 3'b000;
  localparam logic [2:0] EXT_SHAMT = 3'b101;
  localparam logic [2:0] EXT_S     = 3'b001;
  localparam logic [2:0] EXT_B     = 3'b010;
  localparam logic [2:0] EXT_U     = 3'b011;
  localparam logic [2:0] EXT_J     = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/ifetch_predecode.sv
// Combinational pre-decode: picks the immediate extender mode and flags
// opcodes outside the supported RV32I subset.
module ifetch_predecode
  import ifetch_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output logic [2:0] ext_sel,
  output logic       sign,
  output logic       illegal
);

  always_comb begin
    ext_sel = EXT_I;
    illegal = 1'b0;
    case (opcode)
      OP_IMM: begin
        // Shift-immediates carry a 5-bit shamt that must not be sign-extended.
        if (funct3 == 3'b001 || funct3 == 3'b101) ext_sel = EXT_SHAMT;
        else                                      ext_sel = EXT_I;
      end
      LOAD, JALR, OP, SYSTEM: ext_sel = EXT_I;
      STORE:                  ext_sel = EXT_S;
      BRANCH:                 ext_sel = EXT_B;
      LUI, AUIPC:             ext_sel = EXT_U;
      JAL:                    ext_sel = EXT_J;
      default:                illegal = 1'b1;
    endcase
  end

  assign sign = !(ext_sel == EXT_SHAMT || ext_sel == EXT_U);

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: owns the PC, runs the imem request/ack handshake, registers the
// fetched word and presents it to decode with its pre-decoded extender controls.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [24:0] imm,
  output logic [2:0]  ext_sel,
  output logic        sign,
  output logic        illegal,
  output state_e      dbg_state
);

  // Handshakes: imem_req stays high until a cycle with imem_ack=1 completes the
  // fetch; inst_valid stays high, with inst/pc/imm/ext_sel/sign/illegal stable,
  // until a cycle with inst_ready=1 (or a redirect) retires the instruction.

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        kill_q, kill_d;
  logic [31:0] kill_addr_q, kill_addr_d;
  logic        loaded_q, loaded_d;
  logic [31:0] redirect_target;
  logic        illegal_raw;
  logic [1:0]  unused_redirect_lsbs;

  assign redirect_target      = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      inst_q      <= 32'h0;
      pc_out_q    <= 32'h0;
      kill_q      <= 1'b0;
      kill_addr_q <= 32'h0;
      loaded_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      pc_out_q    <= pc_out_d;
      kill_q      <= kill_d;
      kill_addr_q <= kill_addr_d;
      loaded_q    <= loaded_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    pc_out_d    = pc_out_q;
    kill_d      = kill_q;
    kill_addr_d = kill_addr_q;
    loaded_d    = loaded_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect) pc_d = redirect_target;
      end
      S_REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_d   = redirect_target;
            kill_d = 1'b0;
          end else if (kill_q) begin
            kill_d = 1'b0;
          end else begin
            inst_d   = imem_rdata;
            pc_out_d = pc_q;
            loaded_d = 1'b1;
            state_d  = S_HOLD;
          end
        end else if (redirect) begin
          pc_d = redirect_target;
          // The outstanding request keeps its address until memory answers it.
          if (!kill_q) begin
            kill_d      = 1'b1;
            kill_addr_d = pc_q;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_target;
          state_d = S_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req   = (state_q == S_REQ);
  assign imem_addr  = kill_q ? kill_addr_q : pc_q;
  assign inst_valid = (state_q == S_HOLD);
  assign inst       = inst_q;
  assign pc         = pc_out_q;
  assign imm        = inst_q[31:7];
  assign dbg_state  = state_q;

  ifetch_predecode u_predecode (
    .opcode  (inst_q[6:0]),
    .funct3  (inst_q[14:12]),
    .ext_sel (ext_sel),
    .sign    (sign),
    .illegal (illegal_raw)
  );

  // The all-zero reset word is not a real instruction, so it is never flagged.
  assign illegal = illegal_raw & loaded_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: hand-written handshake sequences followed by
// a table of pre-decode vectors fetched through a zero-wait memory.
module tb_ifetch_unit;
  import ifetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [24:0] imm;
  logic [2:0]  ext_sel;
  logic        sign;
  logic        illegal;
  state_e      dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] word;
    logic [24:0] exp_imm;
    logic [2:0]  exp_ext_sel;
    logic        exp_sign;
    logic        exp_illegal;
  } vec_t;

  vec_t vecs[14];

  ifetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .pc          (pc),
    .imm         (imm),
    .ext_sel     (ext_sel),
    .sign        (sign),
    .illegal     (illegal),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_req(input string tag, input logic [31:0] exp_addr);
    check({tag, " req"}, 32'(imem_req), 32'd1);
    check({tag, " addr"}, imem_addr, exp_addr);
    check({tag, " valid"}, 32'(inst_valid), 32'd0);
  endtask

  task automatic check_hold(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_inst);
    check({tag, " valid"}, 32'(inst_valid), 32'd1);
    check({tag, " pc"}, pc, exp_pc);
    check({tag, " inst"}, inst, exp_inst);
    check({tag, " req"}, 32'(imem_req), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " req"}, 32'(imem_req), 32'd0);
    check({tag, " valid"}, 32'(inst_valid), 32'd0);
    check({tag, " pc"}, pc, 32'h0);
    check({tag, " inst"}, inst, 32'h0);
    check({tag, " imm"}, 32'(imm), 32'h0);
    check({tag, " ext_sel"}, 32'(ext_sel), 32'h0);
    check({tag, " sign"}, 32'(sign), 32'd1);
    check({tag, " illegal"}, 32'(illegal), 32'd0);
    check({tag, " state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  // Zero-wait fetch of one word, check the pre-decode fields, then retire it.
  task automatic fetch_check(input int idx);
    int waited;
    waited = 0;
    while (!imem_req && waited < 8) begin
      tick();
      waited++;
    end
    check($sformatf("vec%0d req seen", idx), 32'(imem_req), 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = vecs[idx].word;
    tick();
    imem_ack = 1'b0;
    check($sformatf("vec%0d valid", idx), 32'(inst_valid), 32'd1);
    check($sformatf("vec%0d inst", idx), inst, vecs[idx].word);
    check($sformatf("vec%0d imm", idx), 32'(imm), 32'(vecs[idx].exp_imm));
    check($sformatf("vec%0d ext_sel", idx), 32'(ext_sel), 32'(vecs[idx].exp_ext_sel));
    check($sformatf("vec%0d sign", idx), 32'(sign), 32'(vecs[idx].exp_sign));
    check($sformatf("vec%0d illegal", idx), 32'(illegal), 32'(vecs[idx].exp_illegal));
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{32'hFE01_0113, 25'h1FC_0202, 3'b000, 1'b1, 1'b0}; // addi sp,sp,-32
    vecs[1]  = '{32'h4051_5093, 25'h080_A2A1, 3'b101, 1'b0, 1'b0}; // srai x1,x2,5
    vecs[2]  = '{32'h0011_1093, 25'h000_2221, 3'b101, 1'b0, 1'b0}; // slli x1,x2,1
    vecs[3]  = '{32'h0001_2083, 25'h000_0241, 3'b000, 1'b1, 1'b0}; // lw
    vecs[4]  = '{32'h0000_80E7, 25'h000_0101, 3'b000, 1'b1, 1'b0}; // jalr
    vecs[5]  = '{32'h0011_2223, 25'h000_2244, 3'b001, 1'b1, 1'b0}; // sw
    vecs[6]  = '{32'h0020_8463, 25'h000_4108, 3'b010, 1'b1, 1'b0}; // beq
    vecs[7]  = '{32'h1234_50B7, 25'h024_68A1, 3'b011, 1'b0, 1'b0}; // lui
    vecs[8]  = '{32'h1234_5097, 25'h024_68A1, 3'b011, 1'b0, 1'b0}; // auipc
    vecs[9]  = '{32'h0080_00EF, 25'h001_0001, 3'b100, 1'b1, 1'b0}; // jal
    vecs[10] = '{32'h0020_81B3, 25'h000_4103, 3'b000, 1'b1, 1'b0}; // add
    vecs[11] = '{32'h0000_0073, 25'h000_0000, 3'b000, 1'b1, 1'b0}; // ecall
    vecs[12] = '{32'h0000_000B, 25'h000_0000, 3'b000, 1'b1, 1'b1}; // custom-0
    vecs[13] = '{32'h0000_007F, 25'h000_0000, 3'b000, 1'b1, 1'b1}; // opcode 1111111

    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;
    tick(); tick(); tick();
    check_reset_state("reset");

    // Zero-wait memory, ready high: 0x100, 0x104, 0x108 on alternate cycles.
    reset = 1'b0;
    check("c0 req", 32'(imem_req), 32'd0);
    tick();
    check_req("c1", 32'h100);
    imem_ack = 1'b1; imem_rdata = 32'hFE01_0113;
    tick();
    imem_ack = 1'b0;
    check("c2 valid", 32'(inst_valid), 32'd1);
    check("c2 pc", pc, 32'h100);
    check("c2 imm", 32'(imm), 32'h1FC_0202);
    check("c2 ext_sel", 32'(ext_sel), 32'h0);
    check("c2 sign", 32'(sign), 32'd1);
    check("c2 illegal", 32'(illegal), 32'd0);
    tick();
    check_req("c3", 32'h104);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    tick();
    imem_ack = 1'b0;
    check_hold("c4", 32'h104, 32'h0000_0013);
    tick();
    check_req("c5", 32'h108);
    imem_ack = 1'b1; imem_rdata = 32'h0010_0093; inst_ready = 1'b0;
    tick();
    imem_ack = 1'b0;
    check_hold("c6", 32'h108, 32'h0010_0093);

    // Decode stalls for 4 cycles: outputs frozen, no new request.
    for (int i = 0; i < 4; i++) begin
      tick();
      check_hold($sformatf("stall%0d", i), 32'h108, 32'h0010_0093);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check_req("ws0", 32'h10C);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_req($sformatf("ws%0d", i), 32'h10C);
    end
    imem_ack = 1'b1; imem_rdata = 32'h0020_0113;
    tick();
    imem_ack = 1'b0;
    check_hold("ws done", 32'h10C, 32'h0020_0113);

    // Reset overrides a coincident ack and redirect.
    reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h500; imem_ack = 1'b1;
    tick();
    check_reset_state("mid reset");
    reset = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
    tick();
    check_req("rr c1", 32'h100);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    tick();
    imem_ack = 1'b0;
    check_hold("rr c2", 32'h100, 32'h0000_0013);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check_req("pend", 32'h104);

    // Redirect while the 0x104 fetch is outstanding: stale data dropped.
    redirect = 1'b1; redirect_pc = 32'h203;
    tick();
    redirect = 1'b0;
    check_req("kill0", 32'h104);
    tick();
    check_req("kill1", 32'h104);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    check_req("after kill", 32'h200);
    imem_ack = 1'b1; imem_rdata = 32'h00C0_0093;
    tick();
    imem_ack = 1'b0;
    check_hold("tgt", 32'h200, 32'h00C0_0093);

    // Redirect wins over a coincident inst_ready.
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    inst_ready = 1'b0; redirect = 1'b0;
    check_req("rd+rdy", 32'h300);

    // Redirect with ack in the same cycle: data discarded, new PC fetched.
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0; redirect = 1'b1; redirect_pc = 32'h401;
    tick();
    imem_ack = 1'b0; redirect = 1'b0;
    check_req("rd+ack", 32'h400);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0073;
    tick();
    imem_ack = 1'b0;
    check_hold("rd+ack tgt", 32'h400, 32'h0000_0073);

    // PC wraps modulo 2^32.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    check_req("top", 32'hFFFF_FFFC);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    tick();
    imem_ack = 1'b0;
    check_hold("top hold", 32'hFFFF_FFFC, 32'h0000_0013);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check_req("wrap", 32'h0);

    for (int i = 0; i < 14; i++) fetch_check(i);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch and pre-decode stage of the single-cycle RISC-V CPU. It holds the PC, fetches one word per instruction from instruction memory over a request/acknowledge handshake, and registers the result. It presents the instruction to decode with the immediate field inst[31:7] plus the extender controls (ext_sel, sign) that the downstream immediate extender consumes. Branch and jump redirects from execute reload the PC and squash any in-flight fetch.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- CLK  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high
- imem_req  out  1  fetch request; held high until imem_ack
- imem_addr  out  32  word-aligned fetch address (= pc_q)
- imem_ack  in  1  read data valid this cycle; sampled only while imem_req=1
- imem_rdata  in  32  instruction word
- redirect  in  1  PC redirect (taken branch/jump)
- redirect_pc  in  32  redirect target; bits [1:0] forced to 0
- inst_valid  out  1  inst/pc/imm/ext_sel/sign/illegal valid
- inst_ready  in  1  decode accepts the instruction
- inst  out  32  registered instruction
- pc  out  32  address of inst
- imm  out  25  inst[31:7], raw immediate field for the extender
- ext_sel  out  3  extender mode: 000 I, 101 I-shamt, 001 S, 010 B, 011 U, 100 J
- sign  out  1  1 = sign-extend; 0 for ext_sel 101 and 011
- illegal  out  1  opcode not in the supported set

## Operation
- FSM states:
  - S_IDLE: reset state; lasts one cycle, then goes to S_REQ.
  - S_REQ: imem_req=1, imem_addr=pc_q.
    - On imem_ack with kill=0: capture imem_rdata into inst_q, latch pc, go to S_HOLD.
    - On imem_ack with kill=1: discard the data, clear kill, stay in S_REQ at the new pc_q.
  - S_HOLD: inst_valid=1. When inst_ready=1: pc_q <= pc_q+4, go to S_REQ.
- Redirect (any state, highest priority):
  - pc_q <= {redirect_pc[31:2],2'b00}.
  - In S_HOLD: drop inst_valid, go to S_REQ; a coincident inst_ready is ignored.
  - In S_REQ without ack: set kill; imem_addr keeps the old address until the ack arrives.
  - In S_REQ with ack the same cycle: discard the data, stay in S_REQ with the new PC.
  - In S_IDLE: only the PC is loaded.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
- Pre-decode is combinational from inst_q (opcode inst[6:0], funct3 inst[14:12]):
  - 0010011 with funct3 001 or 101 -> ext_sel 101.
  - Other 0010011, 0000011, 1100111 -> 000.
  - 0100011 -> 001; 1100011 -> 010; 0110111, 0010111 -> 011; 1101111 -> 100.
  - 0110011, 1110011 -> 000, not illegal.
  - Any other opcode -> 000 with illegal=1.
- Outputs other than inst_valid hold their last value while inst_valid=0.

## Timing
- Reset: state S_IDLE, pc_q=RESET_PC, inst_q=0, pc=0, kill=0, imem_req=0, inst_valid=0; imm, ext_sel and illegal are therefore 0, sign=1.
- Zero-wait memory (ack in the request cycle), inst_ready tied high:
  - First imem_req in cycle 1 after Reset falls.
  - inst_valid in cycle 2.
  - Steady state: one instruction per 2 cycles.
- Fetch latency is 1 + N cycles for an N-wait ack.
- inst_valid rises the cycle after an accepted ack and drops the cycle after the inst_ready or redirect handshake.
- Reset mid-operation overrides everything, including a pending ack or redirect; kill is cleared.

## Structure
- Package ifetch_pkg holds:
  - opcode constants (OP_IMM, LOAD, JALR, STORE, BRANCH, LUI, AUIPC, JAL, OP, SYSTEM);
  - EXT_I/EXT_SHAMT/EXT_S/EXT_B/EXT_U/EXT_J encodings (shared with the extender);
  - the state enum.
- Sub-module ifetch_predecode (combinational: inst -> ext_sel, sign, illegal).

## Test plan
- Reset release with RESET_PC=32'h100, zero-wait memory, ready=1 -> imem_addr 0x100, 0x104, 0x108 on alternating cycles; inst_valid in cycle 2.
- imem_rdata 32'hFE010113 (addi sp,sp,-32) -> imm=25'h1FC0202, ext_sel=000, sign=1, illegal=0.
- Three-wait-state ack plus inst_ready held low for 4 cycles -> inst and pc stable while valid, and no new request until ready.
- Redirect to 32'h203 asserted during a pending fetch of 0x104 -> stale data discarded, next request at 0x200, no valid pulse for 0x104.
- Redirect and inst_ready in the same S_HOLD cycle -> next fetch at the redirect target, not pc+4.
- pc_q=32'hFFFF_FFFC, instruction accepted -> next imem_addr=0.
- Opcode 7'b0001011 -> illegal=1, ext_sel=000.
- srai (funct3 101) -> ext_sel=101, sign=0.
